sram_pipe: RTL

SRAM_PIPE -- requirements
Module: sram_pipe

---
 rtl/sram_pipe.sv | 76 +++++++
 1 files changed

// File: rtl/sram_pipe.sv
// rtl/sram_pipe.sv - single-port SRAM with a stallable fixed-latency read pipeline
module sram_pipe #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 16,
    parameter int DEPTH        = 512,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  we_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rsp_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];
    logic [READ_LATENCY-1:0] stg_valid;
    logic [READ_LATENCY-1:0] stg_err;
    logic [DATA_WIDTH-1:0]   stg_data [READ_LATENCY];

    logic                  in_range;
    logic                  accept;
    logic                  rd_accept;
    logic [IDX_W-1:0]      idx;
    logic [DATA_WIDTH-1:0] rd_word;

    assign in_range = ({1'b0, addr} < DEPTH_W);
    assign idx      = addr[IDX_W-1:0];

    always_comb begin
        rsp_valid = stg_valid[READ_LATENCY-1];
        req_ready = !(rsp_valid && !rsp_ready);
        accept    = req_valid && req_ready;
        rd_accept = accept && we_n;
        rd_word   = in_range ? mem[idx] : '0;
        data_out  = rsp_valid ? stg_data[READ_LATENCY-1] : '0;
        rsp_err   = rsp_valid && stg_err[READ_LATENCY-1];
    end

    // Memory is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (accept && !we_n && in_range) begin
            mem[idx] <= data_in;
        end
    end

    // The whole pipe freezes while the output stage holds an unaccepted response.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stg_valid <= '0;
            stg_err   <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                stg_data[i] <= '0;
            end
        end else if (req_ready) begin
            stg_valid[0] <= rd_accept;
            stg_err[0]   <= rd_accept && !in_range;
            stg_data[0]  <= rd_accept ? rd_word : '0;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stg_valid[i] <= stg_valid[i-1];
                stg_err[i]   <= stg_err[i-1];
                stg_data[i]  <= stg_data[i-1];
            end
        end
    end

endmodule
